// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative M-extension multiply/divide sequencer for EX.
// Ports: clk, rst_n (async low), start_i, funct3_i, a_i, b_i, flush_i -> stall_o,
// busy_o, done_o, result_o.  Optional MULDIV_FASTMUL_EN: single-cycle multiplies.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d, acc_nx;

   logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
   logic            is_div, spec, ge;
   logic [XLEN-1:0] ua, ub, spec_res, r_sub;
   logic [XLEN:0]   mul_sum, r_sh;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         3'b010:  a_sgn = 1'b1;
         default: ;
      endcase
   end

   assign is_div = funct3_i[2];
   assign a_neg  = a_sgn & a_i[XLEN-1];
   assign b_neg  = b_sgn & b_i[XLEN-1];
   assign ua     = a_neg ? -a_i : a_i;
   assign ub     = b_neg ? -b_i : b_i;
   // remainder takes the dividend's sign, everything else the xor
   assign neg_in = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

   // divide-by-zero and signed overflow bypass the iteration
   always_comb begin
      spec     = 1'b0;
      spec_res = '0;
      if (is_div && b_i == '0) begin
         spec     = 1'b1;
         spec_res = funct3_i[1] ? a_i : '1;
      end else if (is_div && !funct3_i[0] && a_i == MIN && b_i == '1) begin
         spec     = 1'b1;
         spec_res = funct3_i[1] ? '0 : a_i;
      end
   end

   // one iteration: shift-add for multiply, restoring step for divide
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign r_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign r_sub   = r_sh[XLEN-1:0] - opnd_q;
   assign ge      = r_sh[XLEN] | (r_sh[XLEN-1:0] >= opnd_q);

   always_comb begin
      if (op_q[2])
         acc_nx = {ge ? r_sub : r_sh[XLEN-1:0], acc_q[XLEN-2:0], ge};
      else
         acc_nx = {mul_sum, acc_q[XLEN-1:1]};
   end

   function automatic logic [XLEN-1:0] fin(
      input logic [2:0]      op,
      input logic            neg,
      input logic [2*XLEN-1:0] p
   );
      logic [2*XLEN-1:0] pn;
      logic [XLEN-1:0]   q, r;
      pn = neg ? -p : p;
      q  = neg ? -p[XLEN-1:0] : p[XLEN-1:0];
      r  = neg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
      if (op[2])
         return op[1] ? r : q;
      return (op[1:0] == 2'b00) ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN];
   endfunction

`ifdef MULDIV_FASTMUL_EN
   logic [2*XLEN-1:0] fprod;
   assign fprod = {{XLEN{1'b0}}, ua} * {{XLEN{1'b0}}, ub};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      result_d = result_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_d  = funct3_i;
                  neg_d = neg_in;
                  cnt_d = CW'(XLEN);
                  if (spec) begin
                     result_d = spec_res;
                     state_d  = DONE;
                  end
`ifdef MULDIV_FASTMUL_EN
                  else if (!is_div) begin
                     result_d = fin(funct3_i, neg_in, fprod);
                     state_d  = DONE;
                  end
`endif
                  else begin
                     opnd_d  = is_div ? ub : ua;
                     acc_d   = {{XLEN{1'b0}}, is_div ? ua : ub};
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               acc_d = acc_nx;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  result_d = fin(op_q, neg_q, acc_nx);
                  state_d  = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE) & ~flush_i;
   assign stall_o  = rst_n & ~flush_i &
                     (((state_q == IDLE) & start_i) | (state_q == RUN));
   assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random checks of muldiv_sequencer
// against a plain-arithmetic model (results, latency, stall, flush, reset).
module tb_muldiv_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o, busy_o, done_o;
   logic [31:0] result_o;

   int total = 0;
   int bad = 0;
   logic [31:0] last_res = '0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i),
      .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
      .done_o(done_o), .result_o(result_o)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (f)
         3'd0: p = ua * ub;
         3'd1: p = sa * sb;
         3'd2: p = sa * ub;
         3'd3: p = ua * ub;
         default: ;
      endcase
      case (f)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return 1;
`ifdef MULDIV_FASTMUL_EN
      if (!f[2]) return 1;
`endif
      return 33;
   endfunction

   // called right after a negedge; leaves start_i high in the done cycle
   task automatic run_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
      int cyc, nst, lat;
      logic [31:0] exp;
      exp = model(f, a, b);
      lat = latency(f, a, b);
      start_i  = 1'b1;
      funct3_i = f;
      a_i      = a;
      b_i      = b;
      cyc = 0;
      nst = 0;
      while (1) begin
         #1;
         if (done_o) break;
         if (stall_o) nst++;
         if (cyc >= 100) break;
         @(negedge clk);
         cyc++;
      end
      check({tag, ".timeout"}, {63'b0, done_o}, 64'd1);
      check({tag, ".lat"}, 64'(cyc), 64'(lat));
      check({tag, ".stallcyc"}, 64'(nst), 64'(lat));
      check({tag, ".stall_done"}, {63'b0, stall_o}, 64'd0);
      check({tag, ".res"}, {32'b0, result_o}, {32'b0, exp});
      last_res = exp;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      check("rst.stall", {63'b0, stall_o}, 0);
      check("rst.busy", {63'b0, busy_o}, 0);
      check("rst.done", {63'b0, done_o}, 0);
      check("rst.res", {32'b0, result_o}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
      check("mul.const", {32'b0, result_o}, 64'hFFFF_FFEB);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
      run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op("divu", 3'd5, 32'd100, 32'd7);
      run_op("remu", 3'd7, 32'd100, 32'd7);
      run_op("divu0", 3'd5, 32'd5, 32'd0);
      run_op("remu0", 3'd7, 32'd5, 32'd0);
      run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      for (int i = 0; i < 40; i++)
         run_op("rnd", 3'($urandom_range(0, 7)), pick(), pick());

      // flush a divide at cycle 10
      start_i  = 1'b1;
      funct3_i = 3'd4;
      a_i      = 32'd12345;
      b_i      = 32'd7;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      #1;
      check("flush.stall", {63'b0, stall_o}, 0);
      check("flush.done", {63'b0, done_o}, 0);
      @(negedge clk);
      flush_i = 1'b0;
      start_i = 1'b0;
      #1;
      check("flush.idle", {63'b0, busy_o}, 0);
      check("flush.keep", {32'b0, result_o}, {32'b0, last_res});
      @(negedge clk);
      run_op("postflush", 3'd5, 32'd1000, 32'd9);

      // async reset in the middle of a divide
      start_i  = 1'b1;
      funct3_i = 3'd4;
      a_i      = 32'd999;
      b_i      = 32'd4;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst.stall", {63'b0, stall_o}, 0);
      check("mrst.done", {63'b0, done_o}, 0);
      check("mrst.busy", {63'b0, busy_o}, 0);
      check("mrst.res", {32'b0, result_o}, 0);
      start_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("postrst", 3'd0, 32'd7, 32'hFFFF_FFFD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
